xadac_vrf_stage: RTL
====================

Name: xadac_vrf_stage

Overview:
- Vector register file (VRF) stage of the xadac accelerator, placed between the dispatcher and the execute unit.
- Request path: takes execute requests carrying vector source addresses, reads the VRF, and forwards each request with vs_data filled to the execute-unit slave.
- Response path: accepts execute responses, commits vd writes into the VRF, and returns rd results upstream.
- Each path has a one-entry registered pipeline stage with valid/ready handshakes.

Parameters:
- NoRs, 2, number of scalar source operands
- NoVs, 3, number of vector source operands
- NoVRegs, 32, vector registers (address width RegW = 5)
- VecW, 256, bits per vector register
- XlenW, 32, scalar data width
- IdW, 4, transaction id width
- InstrW, 32, instruction width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- up_req_valid_i  in  1  upstream request valid
- up_req_ready_o  out  1  upstream request ready
- up_req_id_i  in  IdW  transaction id
- up_req_instr_i  in  InstrW  instruction
- up_req_rs_addr_i  in  NoRs*RegW  scalar source addresses
- up_req_rs_data_i  in  NoRs*XlenW  scalar source data
- up_req_vs_addr_i  in  NoVs*RegW  vector source addresses
- dn_req_valid_o  out  1  downstream request valid
- dn_req_ready_i  in  1  downstream request ready
- dn_req_id_o, dn_req_instr_o, dn_req_rs_addr_o, dn_req_rs_data_o, dn_req_vs_addr_o  out  as upstream  registered copies
- dn_req_vs_data_o  out  NoVs*VecW  vector operand data
- dn_rsp_valid_i  in  1  execute response valid
- dn_rsp_ready_o  out  1  execute response ready
- dn_rsp_id_i  in  IdW  response id
- dn_rsp_rd_addr_i  in  RegW  scalar destination
- dn_rsp_rd_data_i  in  XlenW  scalar result
- dn_rsp_rd_write_i  in  1  scalar write enable
- dn_rsp_vd_addr_i  in  RegW  vector destination
- dn_rsp_vd_data_i  in  VecW  vector result
- dn_rsp_vd_write_i  in  1  vector write enable
- up_rsp_valid_o  out  1  response valid to core
- up_rsp_ready_i  in  1  core ready
- up_rsp_id_o, up_rsp_rd_addr_o, up_rsp_rd_data_o, up_rsp_rd_write_o  out  IdW/RegW/XlenW/1  registered response

Behaviour:
- Clocking and reset:
  - Single clock clk_i; reset rst_ni is asynchronous, active-low.
  - During reset: all valids = 0; all data outputs = 0; all VRF entries = 0.
  - up_req_ready_o and dn_rsp_ready_o are 1 while empty (i.e. from the first cycle after reset).
- VRF write:
  - Write strobe wr_en = dn_rsp_valid_i & dn_rsp_ready_o & dn_rsp_vd_write_i.
  - Writes vrf[dn_rsp_vd_addr_i] = dn_rsp_vd_data_i at the clock edge.
  - Register 0 is a normal register (no hardwired zero).
- Request register (one entry, req_full):
  - up_req_ready_o = !req_full | dn_req_ready_i (combinational, no bubble on drain+fill).
  - Capture on up_req_valid_i & up_req_ready_o. Latency is 1 cycle: dn_req_valid_o rises the cycle after capture.
  - Operand i is captured as wr_data when wr_en and dn_rsp_vd_addr_i == vs_addr[i] (write-through bypass); otherwise vrf[vs_addr[i]].
  - Duplicate vs_addr values across operands are legal; each slot is filled independently.
- Held-entry snoop:
  - While req_full and not being replaced, any wr_en whose address matches a held vs_addr[i] overwrites the held vs_data[i] with wr_data. The same write can update multiple slots.
  - Therefore dn_req_vs_data_o always reflects the latest committed VRF contents.
- Drain and ownership:
  - The entry drains on dn_req_valid_o & dn_req_ready_i.
  - Simultaneous drain and capture: the new entry replaces the old, and req_full stays 1.
  - dn_req_* outputs stay stable while dn_req_valid_o=1 and dn_req_ready_i=0, except vs_data snoop updates.
- Response register (one entry, rsp_full):
  - dn_rsp_ready_o = !rsp_full | up_rsp_ready_i.
  - On dn handshake, capture id, rd_addr, rd_data and rd_write. up_rsp_valid_o rises the next cycle.
  - A response is forwarded upstream even when rd_write=0 and vd_write=0 (completion token).
  - The VRF write happens at the same edge as the response capture, independent of the upstream ready.
- Ordering and reset: responses and requests are passed in order; no id reordering. An asserted reset mid-transfer discards both entries immediately.

Test Plan:
- Reset then idle: up_req_ready_o=1, dn_rsp_ready_o=1, all valids 0; a request with vs_addr={1,2,3} yields vs_data all zero one cycle later.
- Response vd_addr=5, vd_data=0xA5 repeated, vd_write=1 in cycle N → request with vs_addr[0]=5 captured in cycle N (bypass) and in cycle N+1 (array) both carry the 0xA5 pattern.
- Request held with dn_req_ready_i=0 and vs_addr={7,7,2}; write to v7=0x1234 → slots 0 and 1 update to 0x1234 next cycle, slot 2 unchanged, other fields unchanged.
- Back-to-back requests with dn_req_ready_i=1 continuously → one request per cycle, ids 0,1,2,3 emitted in order, up_req_ready_o never drops.
- up_rsp_ready_i=0 with a response held → dn_rsp_ready_o=0; a second response stalls and its vd write does not occur until accepted.
- Assert rst_ni mid-stall with both entries full → valids drop immediately and vrf[5] reads 0 afterwards.

Source files
------------

// File: rtl/xadac_vrf_stage_if.sv
// Bundle of the four handshake channels around the xadac VRF stage.
//   up_req_* : dispatcher -> stage execute request (vector source addresses)
//   dn_req_* : stage -> execute unit, same request with vs_data filled in
//   dn_rsp_* : execute unit -> stage response (rd result, vd write)
//   up_rsp_* : stage -> core scalar result / completion token
// modport slave  : the stage's view
// modport master : the environment's view (dispatcher, execute unit, core)
interface xadac_vrf_stage_if #(
   parameter int NoRs   = 2,
   parameter int NoVs   = 3,
   parameter int RegW   = 5,
   parameter int VecW   = 256,
   parameter int XlenW  = 32,
   parameter int IdW    = 4,
   parameter int InstrW = 32
);
   logic                             up_req_valid, up_req_ready;
   logic [IdW-1:0]                   up_req_id;
   logic [InstrW-1:0]                up_req_instr;
   logic [NoRs-1:0][RegW-1:0]        up_req_rs_addr;
   logic [NoRs-1:0][XlenW-1:0]       up_req_rs_data;
   logic [NoVs-1:0][RegW-1:0]        up_req_vs_addr;

   logic                             dn_req_valid, dn_req_ready;
   logic [IdW-1:0]                   dn_req_id;
   logic [InstrW-1:0]                dn_req_instr;
   logic [NoRs-1:0][RegW-1:0]        dn_req_rs_addr;
   logic [NoRs-1:0][XlenW-1:0]       dn_req_rs_data;
   logic [NoVs-1:0][RegW-1:0]        dn_req_vs_addr;
   logic [NoVs-1:0][VecW-1:0]        dn_req_vs_data;

   logic                             dn_rsp_valid, dn_rsp_ready;
   logic [IdW-1:0]                   dn_rsp_id;
   logic [RegW-1:0]                  dn_rsp_rd_addr;
   logic [XlenW-1:0]                 dn_rsp_rd_data;
   logic                             dn_rsp_rd_write;
   logic [RegW-1:0]                  dn_rsp_vd_addr;
   logic [VecW-1:0]                  dn_rsp_vd_data;
   logic                             dn_rsp_vd_write;

   logic                             up_rsp_valid, up_rsp_ready;
   logic [IdW-1:0]                   up_rsp_id;
   logic [RegW-1:0]                  up_rsp_rd_addr;
   logic [XlenW-1:0]                 up_rsp_rd_data;
   logic                             up_rsp_rd_write;

   modport slave (
      input  up_req_valid, up_req_id, up_req_instr, up_req_rs_addr, up_req_rs_data, up_req_vs_addr,
      output up_req_ready,
      output dn_req_valid, dn_req_id, dn_req_instr, dn_req_rs_addr, dn_req_rs_data, dn_req_vs_addr,
             dn_req_vs_data,
      input  dn_req_ready,
      input  dn_rsp_valid, dn_rsp_id, dn_rsp_rd_addr, dn_rsp_rd_data, dn_rsp_rd_write,
             dn_rsp_vd_addr, dn_rsp_vd_data, dn_rsp_vd_write,
      output dn_rsp_ready,
      output up_rsp_valid, up_rsp_id, up_rsp_rd_addr, up_rsp_rd_data, up_rsp_rd_write,
      input  up_rsp_ready
   );

   modport master (
      output up_req_valid, up_req_id, up_req_instr, up_req_rs_addr, up_req_rs_data, up_req_vs_addr,
      input  up_req_ready,
      input  dn_req_valid, dn_req_id, dn_req_instr, dn_req_rs_addr, dn_req_rs_data, dn_req_vs_addr,
             dn_req_vs_data,
      output dn_req_ready,
      output dn_rsp_valid, dn_rsp_id, dn_rsp_rd_addr, dn_rsp_rd_data, dn_rsp_rd_write,
             dn_rsp_vd_addr, dn_rsp_vd_data, dn_rsp_vd_write,
      input  dn_rsp_ready,
      input  up_rsp_valid, up_rsp_id, up_rsp_rd_addr, up_rsp_rd_data, up_rsp_rd_write,
      output up_rsp_ready
   );
endinterface

// File: rtl/xadac_vrf_stage.sv
// xadac VRF stage: reads vector operands for execute requests and commits
// vector results from execute responses.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (clears both entries and the VRF)
//   bus    : xadac_vrf_stage_if.slave (up_req in, dn_req out, dn_rsp in, up_rsp out)
// Each path is a single registered entry; ready is combinational so a drain and
// a fill in the same cycle cost no bubble.
module xadac_vrf_stage #(
   parameter int NoRs    = 2,
   parameter int NoVs    = 3,
   parameter int NoVRegs = 32,
   parameter int VecW    = 256,
   parameter int XlenW   = 32,
   parameter int IdW     = 4,
   parameter int InstrW  = 32
) (
   input logic              clk_i,
   input logic              rst_ni,
   xadac_vrf_stage_if.slave bus
);
   localparam int RegW = $clog2(NoVRegs);

   logic [VecW-1:0]           vrf [NoVRegs];
   logic                      req_full, rsp_full;
   logic                      req_cap, rsp_cap, wr_en;
   logic [NoVs-1:0][VecW-1:0] rd_vs;
   logic [NoVs-1:0]           snoop_hit;

   logic [IdW-1:0]            req_id;
   logic [InstrW-1:0]         req_instr;
   logic [NoRs-1:0][RegW-1:0] req_rs_addr;
   logic [NoRs-1:0][XlenW-1:0] req_rs_data;
   logic [NoVs-1:0][RegW-1:0] req_vs_addr;
   logic [NoVs-1:0][VecW-1:0] req_vs_data;

   logic [IdW-1:0]            rsp_id;
   logic [RegW-1:0]           rsp_rd_addr;
   logic [XlenW-1:0]          rsp_rd_data;
   logic                      rsp_rd_write;

   assign bus.up_req_ready = !req_full | bus.dn_req_ready;
   assign bus.dn_rsp_ready = !rsp_full | bus.up_rsp_ready;
   assign req_cap          = bus.up_req_valid & bus.up_req_ready;
   assign rsp_cap          = bus.dn_rsp_valid & bus.dn_rsp_ready;
   // A stalled response must not commit its vd write until it is accepted.
   assign wr_en            = rsp_cap & bus.dn_rsp_vd_write;

   // Operand read with write-through bypass, plus snoop of the held entry so
   // the forwarded vs_data always matches the latest committed VRF contents.
   for (genvar i = 0; i < NoVs; i++) begin : g_opnd
      assign rd_vs[i]     = (wr_en && bus.dn_rsp_vd_addr == bus.up_req_vs_addr[i])
                            ? bus.dn_rsp_vd_data : vrf[bus.up_req_vs_addr[i]];
      assign snoop_hit[i] = wr_en && (bus.dn_rsp_vd_addr == req_vs_addr[i]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < NoVRegs; r++) vrf[r] <= '0;
      end else if (wr_en) begin
         vrf[bus.dn_rsp_vd_addr] <= bus.dn_rsp_vd_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_full    <= 1'b0;
         req_id      <= '0;
         req_instr   <= '0;
         req_rs_addr <= '0;
         req_rs_data <= '0;
         req_vs_addr <= '0;
         req_vs_data <= '0;
      end else if (req_cap) begin
         // Covers the drain+fill case too: the new entry replaces the old.
         req_full    <= 1'b1;
         req_id      <= bus.up_req_id;
         req_instr   <= bus.up_req_instr;
         req_rs_addr <= bus.up_req_rs_addr;
         req_rs_data <= bus.up_req_rs_data;
         req_vs_addr <= bus.up_req_vs_addr;
         req_vs_data <= rd_vs;
      end else begin
         if (bus.dn_req_ready) req_full <= 1'b0;
         for (int i = 0; i < NoVs; i++)
            if (snoop_hit[i]) req_vs_data[i] <= bus.dn_rsp_vd_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_full     <= 1'b0;
         rsp_id       <= '0;
         rsp_rd_addr  <= '0;
         rsp_rd_data  <= '0;
         rsp_rd_write <= 1'b0;
      end else if (rsp_cap) begin
         rsp_full     <= 1'b1;
         rsp_id       <= bus.dn_rsp_id;
         rsp_rd_addr  <= bus.dn_rsp_rd_addr;
         rsp_rd_data  <= bus.dn_rsp_rd_data;
         rsp_rd_write <= bus.dn_rsp_rd_write;
      end else if (bus.up_rsp_ready) begin
         rsp_full <= 1'b0;
      end
   end

   assign bus.dn_req_valid   = req_full;
   assign bus.dn_req_id      = req_id;
   assign bus.dn_req_instr   = req_instr;
   assign bus.dn_req_rs_addr = req_rs_addr;
   assign bus.dn_req_rs_data = req_rs_data;
   assign bus.dn_req_vs_addr = req_vs_addr;
   assign bus.dn_req_vs_data = req_vs_data;

   assign bus.up_rsp_valid    = rsp_full;
   assign bus.up_rsp_id       = rsp_id;
   assign bus.up_rsp_rd_addr  = rsp_rd_addr;
   assign bus.up_rsp_rd_data  = rsp_rd_data;
   assign bus.up_rsp_rd_write = rsp_rd_write;
endmodule
